// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int unsigned OP_MUL    = 0;
   localparam int unsigned OP_MULH   = 1;
   localparam int unsigned OP_MULHSU = 2;
   localparam int unsigned OP_MULHU  = 3;
   localparam int unsigned OP_DIV    = 4;
   localparam int unsigned OP_DIVU   = 5;
   localparam int unsigned OP_REM    = 6;
   localparam int unsigned OP_REMU   = 7;

   localparam logic [2:0] EXC_NONE = 3'd0;
   localparam logic [2:0] EXC_DIV0 = 3'd1;
   localparam logic [2:0] EXC_OVF  = 3'd2;
   localparam logic [2:0] EXC_ILL  = 3'd3;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider: loads on start, then one quotient bit per cycle.
module mdu_divider #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int unsigned CW = $clog2(XLEN);

   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic [CW-1:0]   cnt_q;
   logic            running_q;
   logic [XLEN:0]   shifted;

   always_comb begin
      shifted   = {rem_q, quo_q[XLEN-1]};
      quotient  = quo_q;
      remainder = rem_q;
      // High during the final iteration, so the caller can move on at the same edge.
      done      = running_q && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else if (start) begin
         quo_q     <= dividend;
         rem_q     <= '0;
         dvs_q     <= divisor;
         cnt_q     <= CW'(XLEN - 1);
         running_q <= 1'b1;
      end else if (running_q) begin
         if (shifted >= {1'b0, dvs_q}) begin
            rem_q <= XLEN'(shifted - {1'b0, dvs_q});
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) running_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV M-extension unit: pipelined multiply, iterative divide, pulse handshake.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [7:0]      ex_sig,
   input  logic [XLEN-1:0] ex_src1,
   input  logic [XLEN-1:0] ex_src2,
   input  logic            ex_out_valid,
   input  logic            ex_flush,
   output logic [XLEN-1:0] ex_result,
   output logic [2:0]      ex_exception,
   output logic            ex_in_valid,
   output logic            ex_busy
);

   localparam int unsigned PW = 2 * XLEN;
   localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            mul_low_q, sel_rem_q, q_neg_q, r_neg_q;

   logic            legal, is_div, is_rem, is_sgn, div0, ovf, accept, div_start, div_done;
   logic [XLEN-1:0] mag1, mag2, div_quo, div_rem, q_fix, r_fix;
   logic signed [XLEN:0]   a_ext, b_ext;
   logic signed [PW-1:0]   prod_now;
   logic [PW-1:0]          mul_tap;

   always_comb begin
      legal     = is_onehot(ex_sig);
      is_div    = ex_sig[OP_DIV] | ex_sig[OP_DIVU];
      is_rem    = ex_sig[OP_REM] | ex_sig[OP_REMU];
      is_sgn    = ex_sig[OP_DIV] | ex_sig[OP_REM];
      div0      = (ex_src2 == '0);
      ovf       = is_sgn && (ex_src1 == INT_MIN) && (ex_src2 == '1);
      accept    = ex_out_valid && !ex_busy && !ex_flush;
      mag1      = (is_sgn && ex_src1[XLEN-1]) ? -ex_src1 : ex_src1;
      mag2      = (is_sgn && ex_src2[XLEN-1]) ? -ex_src2 : ex_src2;
      div_start = accept && legal && (is_div || is_rem) && !div0 && !ovf;
      // One extra bit per operand covers all three signedness combinations.
      a_ext     = {(ex_sig[OP_MULH] | ex_sig[OP_MULHSU]) & ex_src1[XLEN-1], ex_src1};
      b_ext     = {ex_sig[OP_MULH] & ex_src2[XLEN-1], ex_src2};
      prod_now  = PW'(a_ext) * PW'(b_ext);
      q_fix     = q_neg_q ? -div_quo : div_quo;
      r_fix     = r_neg_q ? -div_rem : div_rem;
   end

   // Product enters at the accept edge; the output register is the last stage.
   if (MUL_LAT == 1) begin : g_mul_comb
      assign mul_tap = prod_now;
   end else begin : g_mul_pipe
      logic [PW-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < int'(MUL_LAT) - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= prod_now;
            for (int i = 1; i < int'(MUL_LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign mul_tap = pipe_q[MUL_LAT-2];
   end

   mdu_divider #(
      .XLEN (XLEN)
   ) u_divider (
      .clk       (clk),
      .rstn      (rstn),
      .start     (div_start),
      .dividend  (mag1),
      .divisor   (mag2),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mul_low_q    <= 1'b0;
         sel_rem_q    <= 1'b0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         ex_result    <= '0;
         ex_exception <= EXC_NONE;
         ex_in_valid  <= 1'b0;
         ex_busy      <= 1'b0;
      end else begin
         ex_in_valid <= 1'b0;
         if (ex_flush) begin
            state_q <= IDLE;
            ex_busy <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: if (accept) begin
                  if (!legal) begin
                     ex_in_valid  <= 1'b1;
                     ex_result    <= '0;
                     ex_exception <= EXC_ILL;
                  end else if ((is_div || is_rem) && div0) begin
                     ex_in_valid  <= 1'b1;
                     ex_result    <= is_div ? '1 : ex_src1;
                     ex_exception <= EXC_DIV0;
                  end else if (ovf) begin
                     ex_in_valid  <= 1'b1;
                     ex_result    <= ex_sig[OP_DIV] ? ex_src1 : '0;
                     ex_exception <= EXC_OVF;
                  end else if (is_div || is_rem) begin
                     state_q   <= DIV;
                     ex_busy   <= 1'b1;
                     sel_rem_q <= is_rem;
                     q_neg_q   <= is_sgn && (ex_src1[XLEN-1] ^ ex_src2[XLEN-1]);
                     r_neg_q   <= is_sgn && ex_src1[XLEN-1];
                  end else if (MUL_LAT == 1) begin
                     ex_in_valid  <= 1'b1;
                     ex_result    <= ex_sig[OP_MUL] ? prod_now[XLEN-1:0] : prod_now[PW-1:XLEN];
                     ex_exception <= EXC_NONE;
                  end else begin
                     state_q   <= MUL;
                     ex_busy   <= 1'b1;
                     cnt_q     <= CW'(MUL_LAT - 2);
                     mul_low_q <= ex_sig[OP_MUL];
                  end
               end
               MUL: begin
                  if (cnt_q == '0) begin
                     state_q      <= IDLE;
                     ex_busy      <= 1'b0;
                     ex_in_valid  <= 1'b1;
                     ex_result    <= mul_low_q ? mul_tap[XLEN-1:0] : mul_tap[PW-1:XLEN];
                     ex_exception <= EXC_NONE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               DIV: if (div_done) state_q <= FIX;
               FIX: begin
                  state_q      <= IDLE;
                  ex_busy      <= 1'b0;
                  ex_in_valid  <= 1'b1;
                  ex_result    <= sel_rem_q ? r_fix : q_fix;
                  ex_exception <= EXC_NONE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned MUL_LAT = 3;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic [7:0]  ex_sig = '0;
   logic [31:0] ex_src1 = '0, ex_src2 = '0;
   logic        ex_out_valid = 1'b0, ex_flush = 1'b0;
   logic [31:0] ex_result;
   logic [2:0]  ex_exception;
   logic        ex_in_valid, ex_busy;

   int          n_checks = 0, n_errors = 0;
   logic [31:0] exp_res;
   logic [2:0]  exp_exc;
   int          exp_lat;
   int          inj_k = 0;
   int          stray;

   mdu_iter #(
      .XLEN    (XLEN),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .ex_sig       (ex_sig),
      .ex_src1      (ex_src1),
      .ex_src2      (ex_src2),
      .ex_out_valid (ex_out_valid),
      .ex_flush     (ex_flush),
      .ex_result    (ex_result),
      .ex_exception (ex_exception),
      .ex_in_valid  (ex_in_valid),
      .ex_busy      (ex_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RV M-extension semantics computed with 64-bit arithmetic.
   function automatic void ref_model(input logic [7:0] sig, input logic [31:0] a, b,
                                     output logic [31:0] r, output logic [2:0] e,
                                     output int lat);
      longint      sa, sb, ub, p;
      logic [63:0] pu;
      int          a32, b32;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ub = longint'(b);
      a32 = a;
      b32 = b;
      e = 3'd0;
      lat = 1;
      r = '0;
      if ($countones(sig) != 1) begin
         e = 3'd3;
      end else if (sig[0] || sig[1] || sig[2] || sig[3]) begin
         lat = MUL_LAT;
         pu = 64'(a) * 64'(b);
         if (sig[0]) begin p = sa * sb; r = p[31:0]; end
         else if (sig[1]) begin p = sa * sb; r = p[63:32]; end
         else if (sig[2]) begin p = sa * ub; r = p[63:32]; end
         else r = pu[63:32];
      end else if (b == 0) begin
         e = 3'd1;
         r = (sig[4] || sig[5]) ? 32'hFFFF_FFFF : a;
      end else if ((sig[4] || sig[6]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e = 3'd2;
         r = sig[4] ? a : 32'h0;
      end else begin
         lat = XLEN + 2;
         if (sig[4]) r = a32 / b32;
         else if (sig[6]) r = a32 % b32;
         else if (sig[5]) r = a / b;
         else r = a % b;
      end
   endfunction

   task automatic issue(input logic [7:0] sig, input logic [31:0] a, b);
      ex_sig = sig;
      ex_src1 = a;
      ex_src2 = b;
      ex_out_valid = 1'b1;
      ref_model(sig, a, b, exp_res, exp_exc, exp_lat);
   endtask

   // Call right after issue(); returns at the negedge where the pulse was seen.
   task automatic wait_pulse(input string tag);
      int bad_busy = 0;
      bit got = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (ex_in_valid) begin
            check_eq({tag, "_lat"}, 64'(k), 64'(exp_lat));
            check_eq({tag, "_res"}, 64'(ex_result), 64'(exp_res));
            check_eq({tag, "_exc"}, 64'(ex_exception), 64'(exp_exc));
            if (ex_busy) bad_busy++;
            got = 1'b1;
            break;
         end
         if (ex_busy != (exp_lat > 1)) bad_busy++;
         if (k == inj_k) begin
            ex_sig = 8'h08;
            ex_src1 = $urandom;
            ex_src2 = $urandom;
            ex_out_valid = 1'b1;
         end else begin
            ex_out_valid = 1'b0;
         end
      end
      ex_out_valid = 1'b0;
      check_eq({tag, "_pulse"}, 64'(got), 64'd1);
      check_eq({tag, "_busy"}, 64'(bad_busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] sig, input logic [31:0] a, b);
      issue(sig, a, b);
      wait_pulse(tag);
      @(negedge clk);
      check_eq({tag, "_single"}, 64'(ex_in_valid), 64'd0);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2 rstn = 1'b0;
      @(negedge clk);
      check_eq("rst_res", 64'(ex_result), 64'd0);
      check_eq("rst_exc", 64'(ex_exception), 64'd0);
      check_eq("rst_valid", 64'(ex_in_valid), 64'd0);
      check_eq("rst_busy", 64'(ex_busy), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      run_op("mul", 8'h01, 32'd7, 32'hFFFF_FFFD);
      run_op("mulh", 8'h02, 32'h8000_0000, 32'h8000_0000);
      run_op("mulhu", 8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhsu", 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div", 8'h10, 32'hFFFF_FFF9, 32'd2);
      run_op("rem", 8'h40, 32'hFFFF_FFF9, 32'd2);
      run_op("divu", 8'h20, 32'd100, 32'd7);
      run_op("remu", 8'h80, 32'd100, 32'd7);
      run_op("divu0", 8'h20, 32'd100, 32'd0);
      run_op("remu0", 8'h80, 32'd100, 32'd0);
      run_op("divovf", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("removf", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("illegal", 8'h03, 32'd5, 32'd6);

      inj_k = 5;
      run_op("busy_ign", 8'h10, 32'hFFFF_FFF9, 32'd2);
      inj_k = 0;

      // Flush a divide mid-flight, then issue a multiply the very next cycle.
      stray = 0;
      issue(8'h10, 32'd1000, 32'd3);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         ex_out_valid = 1'b0;
         if (ex_in_valid) stray++;
      end
      ex_flush = 1'b1;
      @(negedge clk);
      ex_flush = 1'b0;
      check_eq("flush_busy", 64'(ex_busy), 64'd0);
      check_eq("flush_valid", 64'(ex_in_valid), 64'd0);
      run_op("after_flush", 8'h01, 32'd12345, 32'd678);
      // Flush beats a simultaneous issue in IDLE.
      ex_sig = 8'h01;
      ex_out_valid = 1'b1;
      ex_flush = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         ex_out_valid = 1'b0;
         ex_flush = 1'b0;
         if (ex_in_valid || ex_busy) stray++;
      end
      check_eq("flush_stray", 64'(stray), 64'd0);

      issue(8'h01, 32'd3, 32'd5);
      wait_pulse("b2b_a");
      issue(8'h08, 32'hDEAD_BEEF, 32'h1234_5678);
      wait_pulse("b2b_b");
      issue(8'h40, 32'hFFFF_FF00, 32'd7);
      wait_pulse("b2b_c");
      @(negedge clk);
      check_eq("b2b_single", 64'(ex_in_valid), 64'd0);

      // Asynchronous reset in the middle of a divide.
      issue(8'h10, 32'h7FFF_FFFF, 32'd9);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ex_out_valid = 1'b0;
      end
      rstn = 1'b0;
      #1;
      check_eq("arst_res", 64'(ex_result), 64'd0);
      check_eq("arst_exc", 64'(ex_exception), 64'd0);
      check_eq("arst_valid", 64'(ex_in_valid), 64'd0);
      check_eq("arst_busy", 64'(ex_busy), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      stray = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ex_in_valid || ex_busy) stray++;
      end
      check_eq("arst_stray", 64'(stray), 64'd0);
      run_op("post_rst", 8'h40, 32'hFFFF_FF9C, 32'd7);

      for (int n = 0; n < 100; n++) begin
         int s;
         logic [7:0] sig;
         s = $urandom_range(0, 9);
         if (s < 8) sig = 8'(1 << s);
         else if (s == 8) sig = 8'h00;
         else sig = 8'($urandom_range(0, 255));
         run_op("rnd", sig, rnd_opnd(), rnd_opnd());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: summary not reached, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle integer multiply/divide unit; successor of the single-slot execution unit on the core's EX path.
- Executes the eight RV M-extension operations at width XLEN.
- Multiply uses a fixed-latency register pipeline. Divide/remainder uses an iterative restoring divider, 1 quotient bit per cycle.
- Uses the core's one-cycle issue-pulse / result-pulse handshake, and adds busy, flush and special-case early-out.

Parameters:
- XLEN, 32, operand/result width (>=8).
- MUL_LAT, 3, cycles from accept to multiply result pulse (>=1).

Ports:
- clk  in  1  clock, all flops rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- ex_sig  in  8  one-hot op: [0]mul [1]mulh [2]mulhsu [3]mulhu [4]div [5]divu [6]rem [7]remu.
- ex_src1  in  XLEN  rs1 operand (multiplicand/dividend).
- ex_src2  in  XLEN  rs2 operand (multiplier/divisor).
- ex_out_valid  in  1  issue pulse from core; sampled only when ex_busy=0.
- ex_flush  in  1  synchronous abort of the in-flight op.
- ex_result  out  XLEN  result, valid while ex_in_valid=1.
- ex_exception  out  3  0 none, 1 divide-by-zero, 2 signed overflow, 3 illegal ex_sig.
- ex_in_valid  out  1  one-cycle result pulse to core.
- ex_busy  out  1  op in flight; issue ignored while high.

Behaviour:
- Reset (rstn=0, async): ex_result=0, ex_exception=0, ex_in_valid=0, ex_busy=0, state IDLE, counters 0. Reset mid-operation discards the op; no pulse follows.
- States: IDLE, MUL, DIV, FIX.
- Accept: edge where ex_out_valid=1, ex_busy=0, ex_flush=0. Operands and op are latched. ex_busy=1 from the next cycle unless the op is an early-out.
- Early-out (IDLE -> IDLE, ex_in_valid 1 cycle after accept, ex_busy stays 0):
  - ex_sig not exactly one-hot: result 0, exc 3.
  - div/divu with src2=0: result all-ones, exc 1.
  - rem/remu with src2=0: result src1, exc 1.
  - div with src1=-2^(XLEN-1) and src2=-1: result src1, exc 2.
  - rem with the same operands: result 0, exc 2.
- MUL: full product of two (XLEN+1)-bit sign/zero-extended operands.
  - mulh: signed x signed. mulhsu: signed src1 x unsigned src2. mulhu: unsigned x unsigned. mul: low XLEN bits.
  - Product is registered through a MUL_LAT-deep pipeline (retimable).
  - ex_in_valid is high exactly MUL_LAT cycles after accept. Then IDLE.
- DIV: operands converted to magnitudes for div/rem; raw for divu/remu.
  - XLEN restoring iterations, one per cycle; counter runs XLEN-1 down to 0, then FIX.
- FIX (1 cycle): quotient negated if operand signs differ (signed ops only). Remainder takes the dividend's sign. Result selected by op.
  - ex_in_valid is high XLEN+2 cycles after accept, exc 0.
- ex_busy:
  - High from the cycle after accept until the cycle ex_in_valid is high.
  - Low in the pulse cycle, so a back-to-back issue is accepted on that edge.
- Issue while busy: ignored. No state change, no exception, no pulse.
- ex_flush:
  - Forces IDLE on the next edge, drops the in-flight op, no ex_in_valid.
  - Flush wins over a simultaneous issue; that issue is dropped.
  - Flush in the pulse cycle does not retract the pulse.
- Outputs hold their last values between pulses. ex_in_valid is never high for 2 consecutive cycles from a single op.

Decomposition:
- Package mdu_pkg holds:
  - op bit index constants (OP_MUL..OP_REMU);
  - exception codes EXC_NONE/EXC_DIV0/EXC_OVF/EXC_ILL;
  - the state enum {IDLE, MUL, DIV, FIX}.
- One sub-module: mdu_divider, the unsigned restoring iteration core.
  - Parameter XLEN.
  - Ports start, dividend, divisor, quotient, remainder, done.
  - mdu_iter owns sign handling, the multiply pipeline, the FSM and the handshake.

Test Plan (XLEN=32, MUL_LAT=3):
- Multiply low: mul 7 x 0xFFFFFFFD -> 0xFFFFFFEB, exc 0, ex_in_valid exactly 3 cycles after accept, ex_busy high for cycles 1-2.
- High-half multiplies:
  - mulh 0x80000000 x 0x80000000 -> 0x40000000.
  - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; each pulses 34 cycles after accept. divu 100/7 -> 14; remu -> 2.
- Special cases, each pulsing 1 cycle after accept with ex_busy never high:
  - divu 100/0 -> 0xFFFFFFFF, exc 1.
  - remu 100/0 -> 100, exc 1.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000, exc 2.
  - ex_sig=0x03 -> 0, exc 3.
- Handshake:
  - Issue at cycle 5 of a div is ignored; the result matches the first op.
  - Flush at cycle 10 of a div gives no pulse and ex_busy low next cycle. A new mul issued the cycle after flush completes normally.
  - Back-to-back issue in the pulse cycle is accepted.
- Async reset: rstn low mid-div (cycle 12) clears all outputs immediately, with no pulse after release. The first op after release is correct.
